uart_tx_fifo: RTL and testbench

//  Serial UART transmitter with write FIFO; drives the processor's tx pin (8N1, optional parity).

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and baud divisor helper.
// Reused by both the tx and rx paths.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Integer divide; the residual rate error is accepted by the far end.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extended pointers; read data is taken straight from the array
// at the read pointer so a pop can be latched by the consumer on the same edge.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // A push while full is dropped even if a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a write FIFO; frames are sent back to back.
// Define UART_TX_PARITY_EN to insert an even parity bit after the data bits (8E1).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         busy,
  output logic                         tx
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             baud_done, start_frame;
  logic             fifo_pop, fifo_empty;
  logic [7:0]       fifo_rd_data;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_en),
    .pop     (fifo_pop),
    .wr_data (wr_data),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign baud_done = (baud_q == BAUD_LAST);
  assign busy      = (state_q != ST_IDLE) || (level != '0);
  assign tx        = tx_q;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q + CNT_W'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d      = '0;
        start_frame = !fifo_empty;
      end
      ST_START: begin
        if (baud_done) begin
          state_d = ST_DATA;
          baud_d  = '0;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_done) begin
          state_d = ST_STOP;
          baud_d  = '0;
        end
      end
`endif
      ST_STOP: begin
        if (baud_done) begin
          state_d     = ST_IDLE;
          baud_d      = '0;
          start_frame = !fifo_empty;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase

    // Popping from IDLE or at the end of STOP keeps consecutive frames gap-free.
    if (start_frame) begin
      fifo_pop = 1'b1;
      state_d  = ST_START;
      shift_d  = fifo_rd_data;
      bit_d    = '0;
      baud_d   = '0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_rd_data;
`endif
    end

    // Line level follows the next state so tx changes on the same edge as the FSM.
    case (state_d)
      ST_START: tx_d = ~IDLE_LEVEL;
      ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at default parameters (DIV = 434).
// Also covers the parity frame when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;

  localparam int DIV = 434;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_BITS = PAR_EN ? 11 : 10;
  localparam int RX_TIMEOUT = 2 * FRAME_BITS * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, busy, tx;
  logic [3:0] level;

  int     vec_cnt = 0;
  int     err_cnt = 0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .level   (level),
    .busy    (busy),
    .tx      (tx)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected line level for frame bit position idx (0 = start bit).
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR_EN && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Line decoder: waits for a start bit, samples mid-bit, returns at mid stop bit.
  task automatic rx_frame(output logic [7:0] data, output logic par,
                          output longint start_cyc, output bit ok);
    int n = 0;
    ok = 1'b1;
    data = 8'h00;
    par = 1'b0;
    start_cyc = 0;
    while (tx !== 1'b0 && n < RX_TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    start_cyc = cyc;
    step(DIV / 2);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(DIV);
      data[i] = tx;
    end
    if (PAR_EN) begin
      step(DIV);
      par = tx;
    end
    step(DIV);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'hAA;
    step(3);
    vec_cnt++; if (tx !== 1'b1) begin err_cnt++; $display("FAIL reset_tx: got %b want 1", tx); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec_cnt++; if (level !== 4'd0) begin err_cnt++; $display("FAIL reset_level: got %0d want 0", level); end
    vec_cnt++; if (full !== 1'b0) begin err_cnt++; $display("FAIL reset_full: got %b want 0", full); end
    reset = 1'b1;
    wr_en = 1'b0;
    step(2);
    vec_cnt++; if (level !== 4'd0 || tx !== 1'b1) begin
      err_cnt++; $display("FAIL reset_release: level %0d tx %b want 0/1", level, tx);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int bad = 0;
    int first_bad = -1;
    logic busy_before = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h55;
    step(1);
    wr_en = 1'b0;
    vec_cnt++; if (level !== 4'd1 || tx !== 1'b1) begin
      err_cnt++; $display("FAIL single_push: level %0d tx %b want 1/1", level, tx);
    end
    step(1);
    vec_cnt++; if (tx !== 1'b0 || level !== 4'd0 || busy !== 1'b1) begin
      err_cnt++; $display("FAIL single_latency: tx %b level %0d busy %b want 0/0/1", tx, level, busy);
    end
    for (int k = 0; k < FRAME_BITS * DIV; k++) begin
      if (tx !== exp_bit(8'h55, k / DIV)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (k == FRAME_BITS * DIV - 1) busy_before = busy;
      step(1);
    end
    vec_cnt++; if (bad != 0) begin
      err_cnt++; $display("FAIL single_waveform: %0d bad samples, first at clk %0d, want 0 bad", bad, first_bad);
    end
    vec_cnt++; if (busy_before !== 1'b1) begin
      err_cnt++; $display("FAIL single_busy_last: got %b want 1", busy_before);
    end
    vec_cnt++; if (busy !== 1'b0 || tx !== 1'b1) begin
      err_cnt++; $display("FAIL single_busy_drop: busy %b tx %b want 0/1", busy, tx);
    end
    $display("test_single 0x55 done");
  endtask

  task automatic test_burst();
    logic [7:0] bytes [3] = '{8'hA5, 8'h3C, 8'hFF};
    logic [7:0] got;
    logic       par;
    longint     st;
    longint     c0;
    bit         ok;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = bytes[i];
      step(1);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_frame(got, par, st, ok);
      vec_cnt++; if (!ok || got !== bytes[i]) begin
        err_cnt++; $display("FAIL burst_data%0d: got %h ok %0d want %h", i, got, ok, bytes[i]);
      end
      if (i > 0) begin
        vec_cnt++; if (st != c0 + 2 + longint'(i) * FRAME_BITS * DIV) begin
          err_cnt++; $display("FAIL burst_gap%0d: start at %0d want %0d", i, st - c0,
                              2 + i * FRAME_BITS * DIV);
        end
      end
      $display("burst frame %0d: %h", i, got);
    end
    step(DIV);
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL burst_idle: busy %b want 0", busy); end
  endtask

  task automatic test_full();
    logic [7:0] bytes [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hC3};
    logic [7:0] got;
    logic       par;
    longint     st;
    bit         ok;
    wr_en = 1'b1;
    wr_data = 8'hFF;
    step(1);
    wr_en = 1'b0;
    step(1);
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1;
      wr_data = bytes[i];
      step(1);
      if (i == 6) begin
        vec_cnt++; if (full !== 1'b0 || level !== 4'd7) begin
          err_cnt++; $display("FAIL full_7: full %b level %0d want 0/7", full, level);
        end
      end
      if (i == 7) begin
        vec_cnt++; if (full !== 1'b1 || level !== 4'd8) begin
          err_cnt++; $display("FAIL full_8: full %b level %0d want 1/8", full, level);
        end
      end
    end
    wr_en = 1'b0;
    vec_cnt++; if (full !== 1'b1 || level !== 4'd8) begin
      err_cnt++; $display("FAIL full_drop: full %b level %0d want 1/8", full, level);
    end
    rx_frame(got, par, st, ok);
    vec_cnt++; if (!ok || got !== 8'hFF) begin
      err_cnt++; $display("FAIL full_first: got %h ok %0d want ff", got, ok);
    end
    for (int i = 0; i < 8; i++) begin
      rx_frame(got, par, st, ok);
      vec_cnt++; if (!ok || got !== bytes[i]) begin
        err_cnt++; $display("FAIL full_frame%0d: got %h ok %0d want %h", i, got, ok, bytes[i]);
      end
      $display("full frame %0d: %h", i, got);
    end
    step(2 * DIV);
    vec_cnt++; if (busy !== 1'b0 || tx !== 1'b1 || level !== 4'd0) begin
      err_cnt++; $display("FAIL full_no_ninth: busy %b tx %b level %0d want 0/1/0", busy, tx, level);
    end
  endtask

  task automatic test_reset_mid(input int bitn);
    logic [7:0] b = 8'h0F;
    int         activity = 0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = (i == 0) ? b : 8'h11 * i[7:0];
      step(1);
    end
    wr_en = 1'b0;
    step((bitn + 1) * DIV + DIV / 2 - 1);
    vec_cnt++; if (tx !== b[bitn] || level !== 4'd2) begin
      err_cnt++; $display("FAIL mid%0d_pre: tx %b level %0d want %b/2", bitn, tx, level, b[bitn]);
    end
    reset = 1'b0;
    step(1);
    vec_cnt++; if (tx !== 1'b1 || level !== 4'd0 || busy !== 1'b0 || full !== 1'b0) begin
      err_cnt++; $display("FAIL mid%0d_reset: tx %b level %0d busy %b full %b want 1/0/0/0",
                          bitn, tx, level, busy, full);
    end
    reset = 1'b1;
    for (int k = 0; k < 2 * DIV; k++) begin
      if (tx !== 1'b1 || busy !== 1'b0) activity++;
      step(1);
    end
    vec_cnt++; if (activity != 0) begin
      err_cnt++; $display("FAIL mid%0d_quiet: %0d active samples want 0", bitn, activity);
    end
    $display("test_reset_mid bit %0d done", bitn);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes [2] = '{8'h07, 8'h03};
    logic       pars  [2] = '{1'b1, 1'b0};
    logic [7:0] got;
    logic       par;
    longint     st;
    bit         ok;
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1;
      wr_data = bytes[i];
      step(1);
      wr_en = 1'b0;
      rx_frame(got, par, st, ok);
      vec_cnt++; if (!ok || got !== bytes[i] || par !== pars[i]) begin
        err_cnt++; $display("FAIL parity%0d: got %h par %b ok %0d want %h par %b",
                            i, got, par, ok, bytes[i], pars[i]);
      end
      step(DIV);
      $display("parity frame %h parity %b", got, par);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_reset_mid(3);
    test_reset_mid(4);
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
